// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_cfg_pkg
//  Purpose  : Shared configuration for the fixed-point arithmetic blocks:
//             default number format, default multiplier latency and the
//             rounding-mode enumeration.
//  Revision : 1.0  initial release
// ============================================================================
package fpga_cfg_pkg;

  // Rounding applied when the 2*WIDTH product is scaled back to WIDTH bits.
  typedef enum logic [1:0] {
    RND_TRUNC      = 2'd0,  // floor (arithmetic shift right)
    RND_HALF_UP    = 2'd1,  // round half toward +infinity
    RND_CONVERGENT = 2'd2   // round half to even
  } round_mode_e;

  localparam int FP_WIDTH              = 32;
  localparam int FP_QFRAC              = 16;
  localparam int FP_MUL_ALWAYS_LATENCY = 3;

endpackage
`default_nettype wire

// File: rtl/fx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : fx_round_sat
//  Purpose  : Combinational scaling of a 2*WIDTH signed product back to a
//             WIDTH-bit fixed-point value: drop QFRAC fraction bits with the
//             selected rounding, then saturate or wrap on overflow.
//  Ports    : p     - full-precision signed product
//             value - rounded (and optionally clamped) result
//             ovf   - rounded value did not fit in WIDTH signed bits
//  Revision : 1.0  initial release
// ============================================================================
module fx_round_sat
  import fpga_cfg_pkg::*;
#(
  parameter int          WIDTH      = FP_WIDTH,
  parameter int          QFRAC      = FP_QFRAC,
  parameter round_mode_e ROUND_MODE = RND_TRUNC,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic signed [2*WIDTH-1:0] p,
  output logic signed [WIDTH-1:0]   value,
  output logic                      ovf
);

  // One guard bit above the product so the round-up increment never wraps.
  localparam int EW = 2*WIDTH + 1;

  localparam logic [QFRAC-1:0]        HALF  = QFRAC'(1) << (QFRAC-1);
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [EW-1:0]  p_ext;
  logic signed [EW-1:0]  trunc_v;
  logic signed [EW-1:0]  rounded;
  logic [QFRAC-1:0]      frac;
  logic                  round_up;
  logic [EW-WIDTH:0]     upper;

  assign p_ext   = {p[2*WIDTH-1], p};
  assign trunc_v = p_ext >>> QFRAC;
  assign frac    = p[QFRAC-1:0];

  // Every mode starts from floor(); the only question is whether to add one.
  always_comb begin
    round_up = 1'b0;
    case (ROUND_MODE)
      RND_HALF_UP:    round_up = frac[QFRAC-1];
      // Exact half: bump only if the floor is odd, landing on the even value.
      RND_CONVERGENT: round_up = (frac == HALF) ? trunc_v[0] : frac[QFRAC-1];
      default:        round_up = 1'b0;
    endcase
  end

  assign rounded = trunc_v + {{(EW-1){1'b0}}, round_up};

  // Fits in WIDTH signed bits iff everything from bit WIDTH-1 up is a copy
  // of the sign.
  assign upper = rounded[EW-1:WIDTH-1];
  assign ovf   = ~((&upper) | ~(|upper));

  always_comb begin
    value = rounded[WIDTH-1:0];
    if (SATURATE && ovf) begin
      value = rounded[EW-1] ? MIN_V : MAX_V;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fx_mul_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fx_mul_stream
//  Purpose  : Streaming signed fixed-point multiplier with valid/ready
//             handshakes on both sides, LATENCY register stages, rounding
//             and saturation ahead of the output register, and a sticky
//             overflow flag.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             in_valid/in_ready     - input handshake, operands a, b
//             out_valid/out_ready   - output handshake, result, ovf
//             ovf_sticky/clr_sticky - latched overflow and its clear
//  Revision : 1.0  initial release
// ============================================================================
module fx_mul_stream
  import fpga_cfg_pkg::*;
#(
  parameter int          WIDTH      = FP_WIDTH,
  parameter int          QFRAC      = FP_QFRAC,
  parameter int          LATENCY    = FP_MUL_ALWAYS_LATENCY,
  parameter round_mode_e ROUND_MODE = RND_TRUNC,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf,
  output logic                    ovf_sticky,
  input  logic                    clr_sticky
);

  logic                     stall;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] rs_p;
  logic                     rs_valid;
  logic signed [WIDTH-1:0]  rs_value;
  logic                     rs_ovf;

  // The whole pipeline moves as one unit: a held output freezes every stage,
  // so the input may only be taken when nothing is stalled.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

  // Stages 1..LATENCY-1 carry the raw product; the last stage holds the
  // already rounded result so the output comes straight from a flop.
  if (LATENCY == 1) begin : g_single
    assign rs_p     = prod;
    assign rs_valid = in_valid;
  end else begin : g_multi
    logic signed [2*WIDTH-1:0] p_q [1:LATENCY-1];
    logic                      v_q [1:LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < LATENCY; i++) begin
          p_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else if (!stall) begin
        p_q[1] <= prod;
        v_q[1] <= in_valid;
        for (int i = 2; i < LATENCY; i++) begin
          p_q[i] <= p_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign rs_p     = p_q[LATENCY-1];
    assign rs_valid = v_q[LATENCY-1];
  end

  fx_round_sat #(
    .WIDTH      (WIDTH),
    .QFRAC      (QFRAC),
    .ROUND_MODE (ROUND_MODE),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .p     (rs_p),
    .value (rs_value),
    .ovf   (rs_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= rs_valid;
      result    <= rs_value;
      ovf       <= rs_valid & rs_ovf;
    end
  end

  // Set has priority over clear so an overflow leaving on the clearing edge
  // is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fx_mul_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx_mul_stream
//  Purpose  : Self-checking bench for fx_mul_stream. Four instances share
//             one stimulus stream: truncate, half-up and convergent with
//             saturation, and truncate with wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fx_mul_stream;
  import fpga_cfg_pkg::*;

  localparam int LAT = 3;
  localparam longint LMAX = 64'sh7FFFFFFF;
  localparam longint LMIN = -64'sh80000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready_tr, in_ready_hu, in_ready_cv, in_ready_wr;
  logic        out_valid_tr, out_valid_hu, out_valid_cv, out_valid_wr;
  logic [31:0] result_tr, result_hu, result_cv, result_wr;
  logic        ovf_tr, ovf_hu, ovf_cv, ovf_wr;
  logic        sticky_tr, sticky_hu, sticky_cv, sticky_wr;

  always #5 clk = ~clk;

  fx_mul_stream #(.WIDTH(32), .QFRAC(16), .LATENCY(LAT), .ROUND_MODE(RND_TRUNC), .SATURATE(1'b1)) u_tr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_tr), .a(a), .b(b),
    .out_valid(out_valid_tr), .out_ready(out_ready), .result(result_tr), .ovf(ovf_tr),
    .ovf_sticky(sticky_tr), .clr_sticky(clr_sticky));
  fx_mul_stream #(.WIDTH(32), .QFRAC(16), .LATENCY(LAT), .ROUND_MODE(RND_HALF_UP), .SATURATE(1'b1)) u_hu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_hu), .a(a), .b(b),
    .out_valid(out_valid_hu), .out_ready(out_ready), .result(result_hu), .ovf(ovf_hu),
    .ovf_sticky(sticky_hu), .clr_sticky(clr_sticky));
  fx_mul_stream #(.WIDTH(32), .QFRAC(16), .LATENCY(LAT), .ROUND_MODE(RND_CONVERGENT), .SATURATE(1'b1)) u_cv (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_cv), .a(a), .b(b),
    .out_valid(out_valid_cv), .out_ready(out_ready), .result(result_cv), .ovf(ovf_cv),
    .ovf_sticky(sticky_cv), .clr_sticky(clr_sticky));
  fx_mul_stream #(.WIDTH(32), .QFRAC(16), .LATENCY(LAT), .ROUND_MODE(RND_TRUNC), .SATURATE(1'b0)) u_wr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_wr), .a(a), .b(b),
    .out_valid(out_valid_wr), .out_ready(out_ready), .result(result_wr), .ovf(ovf_wr),
    .ovf_sticky(sticky_wr), .clr_sticky(clr_sticky));

  typedef struct packed {
    logic [31:0] tr, hu, cv, wr;
    logic        otr, ohu, ocv;
    logic        chk;
    int          t_acc;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic [31:0] tr, hu, cv, wr;
    logic        otr, ohu, ocv;
  } vec_t;

  exp_t        q[$];
  vec_t        vt[13];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pops = 0;
  int          stall_cycles = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;
  logic        prev_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic ovf_of(input longint v);
    return (v > LMAX) || (v < LMIN);
  endfunction

  function automatic logic [31:0] sat_of(input longint v);
    if (v > LMAX) return 32'h7FFFFFFF;
    if (v < LMIN) return 32'h80000000;
    return v[31:0];
  endfunction

  // Reference: exact 64-bit product, then each rounding rule as stated.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    longint p, t, h, c;
    exp_t   e;
    p = longint'($signed(x)) * longint'($signed(y));
    t = p >>> 16;
    h = (p + 64'sd32768) >>> 16;
    if ((p & 64'hFFFF) == 64'h8000) c = t + (t & 64'sd1);
    else                            c = h;
    e     = '0;
    e.tr  = sat_of(t);
    e.hu  = sat_of(h);
    e.cv  = sat_of(c);
    e.wr  = t[31:0];
    e.otr = ovf_of(t);
    e.ohu = ovf_of(h);
    e.ocv = ovf_of(c);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v, input logic lat);
    exp_t e;
    e     = '0;
    e.tr  = v.tr;  e.hu  = v.hu;  e.cv = v.cv; e.wr = v.wr;
    e.otr = v.otr; e.ohu = v.ohu; e.ocv = v.ocv;
    e.chk = lat;
    return e;
  endfunction

  // One clock cycle: check hold behaviour, drive inputs, check in_ready,
  // score any output handshake and record any accepted input.
  task automatic cycle(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ordy, input logic clr, input exp_t e, output logic acc);
    logic stall_now;
    exp_t x;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("hold_out_valid", {31'b0, out_valid_tr}, 32'd1);
      chk("hold_result", result_tr, prev_res);
      chk("hold_ovf", {31'b0, ovf_tr}, {31'b0, prev_ovf});
    end
    in_valid = v; a = aa; b = bb; out_ready = ordy; clr_sticky = clr;
    #1;
    stall_now = out_valid_tr && !ordy;
    if (stall_now) stall_cycles++;
    chk("in_ready", {31'b0, in_ready_tr}, {31'b0, !stall_now});
    acc = v && !stall_now;
    if (out_valid_tr && q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL spurious_out: got out_valid=1, expected none pending (cycle %0d)", cyc);
    end else if (out_valid_tr && ordy) begin
      x = q.pop_front();
      pops++;
      chk("res_trunc", result_tr, x.tr);
      chk("res_halfup", result_hu, x.hu);
      chk("res_conv", result_cv, x.cv);
      chk("res_wrap", result_wr, x.wr);
      chk("ovf_trunc", {31'b0, ovf_tr}, {31'b0, x.otr});
      chk("ovf_halfup", {31'b0, ovf_hu}, {31'b0, x.ohu});
      chk("ovf_conv", {31'b0, ovf_cv}, {31'b0, x.ocv});
      chk("ovf_wrap", {31'b0, ovf_wr}, {31'b0, x.otr});
      if (x.chk) chk("latency", cyc - x.t_acc, LAT);
    end
    if (acc) begin
      e.t_acc = cyc;
      q.push_back(e);
    end
    prev_stall = stall_now;
    prev_res   = result_tr;
    prev_ovf   = ovf_tr;
  endtask

  task automatic drain();
    logic acc;
    int   budget;
    budget = 50;
    while (q.size() > 0 && budget > 0) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
      budget--;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid_tr}, 32'd0);
    chk({tag, "_result"}, result_tr, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ovf_tr}, 32'd0);
    chk({tag, "_sticky"}, {31'b0, sticky_tr}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready_tr}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          k, c, base;
    logic [31:0] ra[8], rb[8];

    //            a             b             trunc         half-up       convergent    wrap          ovf t/h/c
    vt[0]  = '{32'h00018000, 32'h00020000, 32'h00030000, 32'h00030000, 32'h00030000, 32'h00030000, 0, 0, 0};
    vt[1]  = '{32'h00000001, 32'h00008000, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 0, 0, 0};
    vt[2]  = '{32'h00000003, 32'h00008000, 32'h00000001, 32'h00000002, 32'h00000002, 32'h00000001, 0, 0, 0};
    vt[3]  = '{32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0};
    vt[4]  = '{32'h01000000, 32'h01000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 1, 1, 1};
    vt[5]  = '{32'h80000000, 32'h00020000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1};
    vt[6]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFD0000, 32'hFFFD0000, 32'hFFFD0000, 32'hFFFD0000, 0, 0, 0};
    vt[7]  = '{32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0};
    vt[8]  = '{32'h80000000, 32'h00010000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0};
    vt[9]  = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1, 1, 1};
    vt[10] = '{32'h00000005, 32'h00003000, 32'h00000000, 32'h00000001, 32'h00000001, 32'h00000000, 0, 0, 0};
    vt[11] = '{32'h00000005, 32'h00008000, 32'h00000002, 32'h00000003, 32'h00000002, 32'h00000002, 0, 0, 0};
    vt[12] = '{32'hFFFFFFFD, 32'h00008000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0, 0};

    // Reset state, then release between edges so the next edge is the first.
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Table vectors, back to back; the first one also checks latency.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, vt[i].a, vt[i].b, 1'b1, 1'b0, from_vec(vt[i], i == 0), acc);
      chk("table_accept", {31'b0, acc}, 32'd1);
    end
    drain();
    chk("sticky_after_ovf", {31'b0, sticky_tr}, 32'd1);
    chk("sticky_after_ovf_wrap", {31'b0, sticky_wr}, 32'd1);

    // Clear alone, then clear coinciding with an overflow handshake.
    cycle(1'b0, '0, '0, 1'b1, 1'b1, '0, acc);
    @(posedge clk); #1;
    chk("sticky_cleared", {31'b0, sticky_tr}, 32'd0);
    cycle(1'b1, vt[4].a, vt[4].b, 1'b1, 1'b0, from_vec(vt[4], 1'b1), acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, '0, acc);
    chk("clr_edge_has_ovf_out", {31'b0, out_valid_tr & ovf_tr}, 32'd1);
    @(posedge clk); #1;
    chk("sticky_set_wins", {31'b0, sticky_tr}, 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1, '0, acc);
    @(posedge clk); #1;
    chk("sticky_clr_later", {31'b0, sticky_tr}, 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);

    // Backpressure: 8 inputs, out_ready low for 4 cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom();
      rb[i] = {{14{ra[i][0]}}, 18'($urandom_range(0, 32'h3FFFF))};
    end
    ra[2] = 32'h01000000; rb[2] = 32'h01000000;
    k = 0; c = 0; base = pops; stall_cycles = 0;
    while ((k < 8 || q.size() > 0) && c < 60) begin
      cycle(k < 8, ra[k % 8], rb[k % 8], !(c >= 4 && c < 8), 1'b0, model(ra[k % 8], rb[k % 8]), acc);
      if (acc) k++;
      c++;
    end
    chk("bp_all_accepted", k, 8);
    chk("bp_delivered", pops - base, 8);
    chk("bp_stall_seen", stall_cycles, 4);
    q.delete();

    // Reset with three transfers in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, vt[6 + i].a, vt[6 + i].b, 1'b1, 1'b0, from_vec(vt[6 + i], 1'b0), acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
    cycle(1'b1, vt[2].a, vt[2].b, 1'b1, 1'b0, from_vec(vt[2], 1'b1), acc);
    chk("post_rst_accept", {31'b0, acc}, 32'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
